// File: rtl/div_issue_queue_if.sv
// rtl/div_issue_queue_if.sv - issue, CDB snoop and divider dispatch signals of the divider reservation station
interface div_issue_queue_if #(
    parameter int EU_CTL_LEN  = 4,
    parameter int XLEN        = 64,
    parameter int ROB_IDX_LEN = 5
);
    logic                   issue_valid_i;
    logic                   issue_ready_o;
    logic [EU_CTL_LEN-1:0]  issue_eu_ctl_i;
    logic                   issue_rs1_ready_i;
    logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i;
    logic [XLEN-1:0]        issue_rs1_value_i;
    logic                   issue_rs2_ready_i;
    logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i;
    logic [XLEN-1:0]        issue_rs2_value_i;
    logic [ROB_IDX_LEN-1:0] issue_dest_idx_i;
    logic                   cdb_valid_i;
    logic [ROB_IDX_LEN-1:0] cdb_rob_idx_i;
    logic [XLEN-1:0]        cdb_value_i;
    logic                   eu_valid_o;
    logic                   eu_ready_i;
    logic [EU_CTL_LEN-1:0]  eu_ctl_o;
    logic [ROB_IDX_LEN-1:0] eu_rob_idx_o;
    logic [XLEN-1:0]        eu_rs1_value_o;
    logic [XLEN-1:0]        eu_rs2_value_o;

    modport master (
        output issue_valid_i, issue_eu_ctl_i, issue_rs1_ready_i, issue_rs1_idx_i,
               issue_rs1_value_i, issue_rs2_ready_i, issue_rs2_idx_i, issue_rs2_value_i,
               issue_dest_idx_i, cdb_valid_i, cdb_rob_idx_i, cdb_value_i, eu_ready_i,
        input  issue_ready_o, eu_valid_o, eu_ctl_o, eu_rob_idx_o, eu_rs1_value_o, eu_rs2_value_o
    );

    modport slave (
        input  issue_valid_i, issue_eu_ctl_i, issue_rs1_ready_i, issue_rs1_idx_i,
               issue_rs1_value_i, issue_rs2_ready_i, issue_rs2_idx_i, issue_rs2_value_i,
               issue_dest_idx_i, cdb_valid_i, cdb_rob_idx_i, cdb_value_i, eu_ready_i,
        output issue_ready_o, eu_valid_o, eu_ctl_o, eu_rob_idx_o, eu_rs1_value_o, eu_rs2_value_o
    );
endinterface

// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - age-ordered reservation station feeding the integer divider
module div_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int EU_CTL_LEN  = 4,
    parameter int XLEN        = 64,
    parameter int ROB_IDX_LEN = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    div_issue_queue_if.slave bus
);
    logic [DEPTH-1:0]       valid;
    logic [EU_CTL_LEN-1:0]  ctl     [DEPTH];
    logic [ROB_IDX_LEN-1:0] dest    [DEPTH];
    logic [DEPTH-1:0]       rs1_rdy;
    logic [DEPTH-1:0]       rs2_rdy;
    logic [ROB_IDX_LEN-1:0] rs1_idx [DEPTH];
    logic [ROB_IDX_LEN-1:0] rs2_idx [DEPTH];
    logic [XLEN-1:0]        rs1_val [DEPTH];
    logic [XLEN-1:0]        rs2_val [DEPTH];
    // age[i][j] = entry i is older than entry j
    logic [DEPTH-1:0]       age     [DEPTH];

    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] sel;
    logic [DEPTH-1:0] fire;
    logic             alloc;
    logic             found;
    logic             dispatch;
    logic             new_rs1_hit;
    logic             new_rs2_hit;

    logic [EU_CTL_LEN-1:0]  out_ctl;
    logic [ROB_IDX_LEN-1:0] out_rob;
    logic [XLEN-1:0]        out_rs1;
    logic [XLEN-1:0]        out_rs2;

    always_comb begin
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign bus.issue_ready_o = ~&valid;
    assign alloc       = bus.issue_valid_i && bus.issue_ready_o;
    assign new_rs1_hit = bus.cdb_valid_i && (bus.cdb_rob_idx_i == bus.issue_rs1_idx_i);
    assign new_rs2_hit = bus.cdb_valid_i && (bus.cdb_rob_idx_i == bus.issue_rs2_idx_i);

    // Oldest-ready pick: an eligible entry loses if any other eligible entry is older.
    always_comb begin
        elig = valid & rs1_rdy & rs2_rdy;
        sel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = elig[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && elig[j] && age[j][i]) sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        out_ctl = '0;
        out_rob = '0;
        out_rs1 = '0;
        out_rs2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            out_ctl = out_ctl | ({EU_CTL_LEN{sel[i]}}  & ctl[i]);
            out_rob = out_rob | ({ROB_IDX_LEN{sel[i]}} & dest[i]);
            out_rs1 = out_rs1 | ({XLEN{sel[i]}}        & rs1_val[i]);
            out_rs2 = out_rs2 | ({XLEN{sel[i]}}        & rs2_val[i]);
        end
    end

    assign bus.eu_valid_o     = |elig;
    assign bus.eu_ctl_o       = out_ctl;
    assign bus.eu_rob_idx_o   = out_rob;
    assign bus.eu_rs1_value_o = out_rs1;
    assign bus.eu_rs2_value_o = out_rs2;
    assign dispatch           = bus.eu_valid_o && bus.eu_ready_i;
    assign fire               = sel & {DEPTH{dispatch}};

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fire[i]) begin
                    valid[i] <= 1'b0;
                end else if (alloc && alloc_oh[i]) begin
                    valid[i]   <= 1'b1;
                    ctl[i]     <= bus.issue_eu_ctl_i;
                    dest[i]    <= bus.issue_dest_idx_i;
                    rs1_idx[i] <= bus.issue_rs1_idx_i;
                    rs2_idx[i] <= bus.issue_rs2_idx_i;
                    rs1_rdy[i] <= bus.issue_rs1_ready_i || new_rs1_hit;
                    rs2_rdy[i] <= bus.issue_rs2_ready_i || new_rs2_hit;
                    rs1_val[i] <= bus.issue_rs1_ready_i ? bus.issue_rs1_value_i : bus.cdb_value_i;
                    rs2_val[i] <= bus.issue_rs2_ready_i ? bus.issue_rs2_value_i : bus.cdb_value_i;
                end else if (valid[i]) begin
                    if (!rs1_rdy[i] && bus.cdb_valid_i && bus.cdb_rob_idx_i == rs1_idx[i]) begin
                        rs1_rdy[i] <= 1'b1;
                        rs1_val[i] <= bus.cdb_value_i;
                    end
                    if (!rs2_rdy[i] && bus.cdb_valid_i && bus.cdb_rob_idx_i == rs2_idx[i]) begin
                        rs2_rdy[i] <= 1'b1;
                        rs2_val[i] <= bus.cdb_value_i;
                    end
                end
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc && alloc_oh[i])      age[i][j] <= 1'b0;
                    else if (alloc && alloc_oh[j]) age[i][j] <= valid[i] && !fire[i];
                    else if (fire[j])              age[i][j] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_issue_queue.sv
// tb/tb_div_issue_queue.sv - scoreboard bench for div_issue_queue
module tb_div_issue_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    div_issue_queue_if #(.EU_CTL_LEN(4), .XLEN(64), .ROB_IDX_LEN(5)) bus ();

    div_issue_queue #(.DEPTH(4), .EU_CTL_LEN(4), .XLEN(64), .ROB_IDX_LEN(5)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic [4:0]  rob;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_disp(input logic [3:0] c, input logic [4:0] r, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e.ctl = c; e.rob = r; e.rs1 = a; e.rs2 = b;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [4:0] d,
                         input logic r1, input logic [4:0] i1, input logic [63:0] v1,
                         input logic r2, input logic [4:0] i2, input logic [63:0] v2);
        bus.issue_valid_i     = 1'b1;
        bus.issue_eu_ctl_i    = c;
        bus.issue_dest_idx_i  = d;
        bus.issue_rs1_ready_i = r1;
        bus.issue_rs1_idx_i   = i1;
        bus.issue_rs1_value_i = v1;
        bus.issue_rs2_ready_i = r2;
        bus.issue_rs2_idx_i   = i2;
        bus.issue_rs2_value_i = v2;
        step();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] idx, input logic [63:0] v);
        bus.cdb_valid_i   = 1'b1;
        bus.cdb_rob_idx_i = idx;
        bus.cdb_value_i   = v;
        step();
        bus.cdb_valid_i = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_eu_valid"}, 64'(bus.eu_valid_o), 64'd0);
        chk({tag, "_issue_ready"}, 64'(bus.issue_ready_o), 64'd1);
        chk({tag, "_outputs"}, bus.eu_rs1_value_o | bus.eu_rs2_value_o |
            64'(bus.eu_ctl_o) | 64'(bus.eu_rob_idx_o), 64'd0);
    endtask

    // Monitor: every accepted dispatch is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !flush && bus.eu_valid_o && bus.eu_ready_i) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL dispatch_unexpected: got rob %0d rs1 %0d rs2 %0d expected none",
                         bus.eu_rob_idx_o, bus.eu_rs1_value_o, bus.eu_rs2_value_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.eu_ctl_o !== e.ctl || bus.eu_rob_idx_o !== e.rob ||
                    bus.eu_rs1_value_o !== e.rs1 || bus.eu_rs2_value_o !== e.rs2) begin
                    n_err++;
                    $display("FAIL dispatch: got ctl %0h rob %0d rs1 %0d rs2 %0d expected ctl %0h rob %0d rs1 %0d rs2 %0d",
                             bus.eu_ctl_o, bus.eu_rob_idx_o, bus.eu_rs1_value_o, bus.eu_rs2_value_o,
                             e.ctl, e.rob, e.rs1, e.rs2);
                end
            end
        end
    end

    initial begin
        bus.issue_valid_i = 1'b0;  bus.issue_eu_ctl_i = '0;   bus.issue_dest_idx_i = '0;
        bus.issue_rs1_ready_i = 1'b0; bus.issue_rs1_idx_i = '0; bus.issue_rs1_value_i = '0;
        bus.issue_rs2_ready_i = 1'b0; bus.issue_rs2_idx_i = '0; bus.issue_rs2_value_i = '0;
        bus.cdb_valid_i = 1'b0; bus.cdb_rob_idx_i = '0; bus.cdb_value_i = '0;
        bus.eu_ready_i = 1'b0;
        step(); step();
        chk_idle("reset");
        rst_n = 1'b1;

        // Both operands ready: dispatch one cycle after allocation.
        bus.eu_ready_i = 1'b1;
        expect_disp(4'h1, 5'd1, 64'd100, 64'd7);
        issue(4'h1, 5'd1, 1'b1, 5'd0, 64'd100, 1'b1, 5'd0, 64'd7);
        chk("t1_latency", 64'(bus.eu_valid_o), 64'd1);
        step();
        chk("t1_empty", 64'(bus.eu_valid_o), 64'd0);

        // rs1 waits on ROB 3, broadcast two cycles later.
        expect_disp(4'h2, 5'd2, 64'd40, 64'd5);
        issue(4'h2, 5'd2, 1'b0, 5'd3, 64'd0, 1'b1, 5'd0, 64'd5);
        chk("t2_waiting", 64'(bus.eu_valid_o), 64'd0);
        step();
        cdb(5'd3, 64'd40);
        chk("t2_after_cdb", 64'(bus.eu_valid_o), 64'd1);
        step();

        // CDB hits the allocating instruction's rs2 in the same cycle.
        expect_disp(4'h3, 5'd3, 64'd81, 64'd9);
        bus.cdb_valid_i = 1'b1; bus.cdb_rob_idx_i = 5'd6; bus.cdb_value_i = 64'd9;
        issue(4'h3, 5'd3, 1'b1, 5'd0, 64'd81, 1'b0, 5'd6, 64'd0);
        bus.cdb_valid_i = 1'b0;
        chk("t3_same_cycle_capture", 64'(bus.eu_valid_o), 64'd1);
        step();

        // Fill all four entries while the divider stalls; fifth issue ignored.
        bus.eu_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_disp(4'(4 + k), 5'(20 + k), 64'(1000 + k), 64'(10 + k));
            issue(4'(4 + k), 5'(20 + k), 1'b1, 5'd0, 64'(1000 + k), 1'b1, 5'd0, 64'(10 + k));
        end
        chk("t4_full", 64'(bus.issue_ready_o), 64'd0);
        issue(4'hF, 5'd30, 1'b1, 5'd0, 64'd7777, 1'b1, 5'd0, 64'd8888);
        chk("t4_still_full", 64'(bus.issue_ready_o), 64'd0);
        chk("t4_stall_valid", 64'(bus.eu_valid_o), 64'd1);
        bus.eu_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t4_drained", 64'(bus.eu_valid_o), 64'd0);

        // Out-of-order release and age order across slot reuse: B, A, E, C.
        bus.eu_ready_i = 1'b0;
        expect_disp(4'h6, 5'd11, 64'd50, 64'd2);
        expect_disp(4'h5, 5'd10, 64'd22, 64'd3);
        expect_disp(4'h8, 5'd13, 64'd60, 64'd6);
        expect_disp(4'h7, 5'd14, 64'd99, 64'd13);
        issue(4'h6, 5'd11, 1'b1, 5'd0, 64'd50, 1'b1, 5'd0, 64'd2);
        issue(4'h5, 5'd10, 1'b0, 5'd2, 64'd0, 1'b1, 5'd0, 64'd3);
        issue(4'h7, 5'd14, 1'b1, 5'd0, 64'd99, 1'b0, 5'd15, 64'd0);
        bus.eu_ready_i = 1'b1;
        step();
        bus.eu_ready_i = 1'b0;
        chk("t5_b_only_ready", 64'(bus.eu_valid_o), 64'd0);
        issue(4'h8, 5'd13, 1'b1, 5'd0, 64'd60, 1'b1, 5'd0, 64'd6);
        cdb(5'd2, 64'd22);
        bus.eu_ready_i = 1'b1;
        step(); step();
        chk("t5_c_waiting", 64'(bus.eu_valid_o), 64'd0);
        cdb(5'd15, 64'd13);
        step();
        chk("t5_drained", 64'(bus.eu_valid_o), 64'd0);

        // Flush with three entries held.
        bus.eu_ready_i = 1'b0;
        for (int k = 0; k < 3; k++)
            issue(4'h9, 5'(k), 1'b1, 5'd0, 64'(k), 1'b1, 5'd0, 64'(k));
        chk("t6_held", 64'(bus.eu_valid_o), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_idle("flush");

        // Reset while dispatching.
        expect_disp(4'hA, 5'd1, 64'd11, 64'd12);
        issue(4'hA, 5'd1, 1'b1, 5'd0, 64'd11, 1'b1, 5'd0, 64'd12);
        issue(4'hB, 5'd2, 1'b1, 5'd0, 64'd21, 1'b1, 5'd0, 64'd22);
        issue(4'hC, 5'd3, 1'b1, 5'd0, 64'd31, 1'b1, 5'd0, 64'd32);
        bus.eu_ready_i = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        chk_idle("mid_reset");
        rst_n = 1'b1;
        bus.eu_ready_i = 1'b0;
        step();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
